// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - MIPS32 coprocessor-0 register file
//
// Purpose: holds the CP0 registers of the 5-stage core.
//   - Write-back stage write port.
//   - Combinational read port for the execute stage.
//   - Count/Compare timer, which is only present when CP0_TIMER_EN is defined.
//   - Hardware interrupt sampling.
//   - Exception state (EPC, Cause, Status.EXL) driven by the mem-stage resolver.
//
// Optional feature macro: CP0_TIMER_EN
//   Defined:   Count (reg 9), Compare (reg 11) and timer_int_o are implemented.
//   Undefined: count_o and compare_o read as 0, writes to regs 9/11 are
//              ignored, and timer_int_o is tied to 0.
//
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   we_i, waddr_i, data_i    CP0 write port (wb stage)
//   raddr_i, data_o          CP0 read port (ex stage), combinational
//   int_i                    external hardware interrupt lines, go to Cause[15:10]
//   excepttype_i             exception code from the mem stage (0 = none)
//   cur_inst_addr_i          PC of the excepting instruction
//   in_delayslot_i           the excepting instruction sits in a delay slot
//   count_o .. prid_o        direct views of the CP0 registers
//   timer_int_o              sticky timer interrupt level
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cur_inst_addr_i,
  input  logic        in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, cause_q, epc_q;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;

  // Map the resolver's exception type onto a Cause.ExcCode value.
  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 5'd0;
    case (excepttype_i)
      32'h0000_0001: exc_code = 5'd0;
      32'h0000_0008: exc_code = 5'd8;
      32'h0000_000a: exc_code = 5'd10;
      32'h0000_000c: exc_code = 5'd12;
      32'h0000_000d: exc_code = 5'd13;
      default:       exc_valid = 1'b0;
    endcase
  end

  assign eret = (excepttype_i == 32'h0000_000e);

  // Exception handling is placed after the write decode, so that a same-cycle
  // exception overrides a software write to the same field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= STATUS_RST;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      cause_q[15:10] <= int_i;
      if (we_i) begin
        case (waddr_i)
          5'd12: status_q <= data_i;
          5'd13: begin
            cause_q[9:8]   <= data_i[9:8];
            cause_q[23:22] <= data_i[23:22];
          end
          5'd14: epc_q <= data_i;
          default: ;
        endcase
      end
      if (exc_valid) begin
        // A nested exception (EXL already set) keeps the original EPC and BD.
        if (!status_q[1]) begin
          epc_q       <= in_delayslot_i ? cur_inst_addr_i - 32'd4 : cur_inst_addr_i;
          cause_q[31] <= in_delayslot_i;
          status_q[1] <= 1'b1;
        end
        cause_q[6:2] <= exc_code;
      end else if (eret) begin
        status_q[1] <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        timer_q;

  // A Compare of 0 never raises the timer interrupt.
  // A Compare write clears the interrupt, and that clear wins over a
  // match in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      if (we_i && waddr_i == 5'd9) count_q <= data_i;
      else                         count_q <= count_q + 32'd1;
      if (compare_q != 32'd0 && count_q == compare_q) timer_q <= 1'b1;
      if (we_i && waddr_i == 5'd11) begin
        compare_q <= data_i;
        timer_q   <= 1'b0;
      end
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;
`else
  assign count_o     = 32'd0;
  assign compare_o   = 32'd0;
  assign timer_int_o = 1'b0;
`endif

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

  // The read path has no write bypass; the ex stage forwards pending writes.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      5'd9:    data_o = count_o;
      5'd11:   data_o = compare_o;
      5'd12:   data_o = status_q;
      5'd13:   data_o = cause_q;
      5'd14:   data_o = epc_q;
      5'd15:   data_o = PRID_VALUE;
      5'd16:   data_o = CONFIG_VALUE;
      default: data_o = 32'd0;
    endcase
  end

endmodule
